regwrite_scheduler: RTL and testbench
=====================================

# regwrite_scheduler

Write-port scheduler in front of the register bank. Accepts writeback requests from three pipeline sources (ALU, memory, multiply), arbitrates them round-robin onto the bank's two general write ports and its PC update port, and drives those ports from registers. It sits between the writeback stage and the register bank, so that no more than two general writes and one PC write reach the bank per cycle and two writes never target the same register in the same cycle.

## Interface
- N, 32, data width of register/PC values
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  pipeline stall; blocks all grants while high
- req_valid  in  3  per-requester request valid (bit 0 ALU, 1 MEM, 2 MUL)
- req_addr0 / req_addr1 / req_addr2  in  4  destination register per requester
- req_data0 / req_data1 / req_data2  in  N  write data per requester
- req_ready  out  3  per-requester grant; handshake = valid & ready
- write_address / write_data / write_enable  out  4 / N / 1  bank write port 1
- write_address2 / write_data2 / write_enable2  out  4 / N / 1  bank write port 2
- pc_update / pc_write  out  N / 1  bank PC update port
- conflict  out  1  registered pulse: at least one valid request was deferred last cycle

## Operation
- Arbitration state: rr_ptr (0..2). Scan order each cycle is rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
- Walk the requesters in scan order, taking only those with valid high:
  - addr == 15: grant to the PC port if the PC port is still free this cycle; otherwise defer.
  - addr != 15: grant to port 1 if free, else to port 2 if free, else defer.
  - Address clash: a request whose addr equals the addr of a request already granted this cycle is deferred, even if a port is free.
- req_ready[i] is combinational: it is high exactly when requester i is granted this cycle. It depends on req_valid; requesters must not use it to decide whether to raise valid.
- If stall is high, no request is granted: req_ready = 0 and no grant is registered.
- Port contents are registered at the clock edge of the handshake cycle:
  - Port 1 gets the first non-PC grant in scan order; port 2 gets the second.
  - An unused port has its enable at 0; its address and data hold their previous values.
- rr_ptr update at the edge: if any grant occurred, rr_ptr = (index of the first granted requester in scan order) + 1 mod 3. If nothing was granted, rr_ptr is unchanged.
- conflict is registered as: some valid request was not granted while stall was low.
- A deferred requester keeps valid, addr and data stable until it is granted. The bank sees writes to the same register in different cycles in grant order.
- write_address and write_address2 are never equal while both enables are high.

## Timing
- Reset values: write_enable, write_enable2, pc_write, conflict = 0; write_address, write_address2 = 0; write_data, write_data2, pc_update = 0; rr_ptr = 0.
- Latency: the handshake happens in cycle T; the bank write enables are high in cycle T+1 and the bank commits at the end of T+1.
- Enables are single-cycle pulses per grant. Back-to-back grants produce back-to-back pulses.
- Throughput: up to 2 general writes plus 1 PC write per cycle.
- Reset mid-operation: rst wins over all grants at the edge. Requests that handshook in the same cycle as rst are dropped (no write is issued). Outputs return to reset values at that edge, and req_ready is 0 while rst is high.
- A stall asserted in cycle T does not cancel a write registered at the end of T-1; that write is still issued in T.

## Test plan
- Single write: after reset, req_valid=001, req_addr0=3, req_data0=0x0A -> req_ready=001 in the same cycle. Next cycle: write_enable=1, write_address=3, write_data=0x0A, write_enable2=0, pc_write=0.
- Oversubscription and fairness: rr_ptr=0, all three valid with addrs 1, 2, 3 -> ready=011, port1=r1, port2=r2, conflict=1 next cycle, rr_ptr=1. Requesters 0 and 1 drop valid -> requester 2 granted on port 1 in the following cycle.
- Address clash: req0 and req1 both to r5 (data 0x11, 0x22), rr_ptr=0 -> only req0 granted, port1=r5/0x11, write_enable2=0. Next cycle req1 is granted (r5/0x22), so the bank ends holding 0x22.
- PC routing: req0 r15/0x100, req1 r4/0x7, req2 r15/0x200, rr_ptr=0 -> pc_write=1 with pc_update=0x100, port1=r4/0x7, req2 deferred. Next cycle pc_update=0x200.
- Stall: all requesters valid and stall=1 for 3 cycles -> req_ready=000 and all enables 0 during the stall. After the stall is released, grants resume from the unchanged rr_ptr.
- Reset mid-operation: handshake on req0 (r6) in the same cycle rst=1 -> write_enable=0 next cycle, rr_ptr=0, and all outputs at reset values.

Source files
------------

// File: rtl/regwrite_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : regwrite_scheduler_if
//  Brief    : Writeback request / register-bank write-port bundle.
//  Revision : 1.0  initial release
// ============================================================================
interface regwrite_scheduler_if #(
    parameter int N = 32
);
    logic           stall;
    logic [2:0]     req_valid;
    logic [3:0]     req_addr0;
    logic [3:0]     req_addr1;
    logic [3:0]     req_addr2;
    logic [N-1:0]   req_data0;
    logic [N-1:0]   req_data1;
    logic [N-1:0]   req_data2;
    logic [2:0]     req_ready;

    logic [3:0]     write_address;
    logic [N-1:0]   write_data;
    logic           write_enable;
    logic [3:0]     write_address2;
    logic [N-1:0]   write_data2;
    logic           write_enable2;
    logic [N-1:0]   pc_update;
    logic           pc_write;
    logic           conflict;

    // Pipeline / requester side
    modport master (
        output stall, req_valid,
        output req_addr0, req_addr1, req_addr2,
        output req_data0, req_data1, req_data2,
        input  req_ready,
        input  write_address, write_data, write_enable,
        input  write_address2, write_data2, write_enable2,
        input  pc_update, pc_write, conflict
    );

    // Scheduler side
    modport slave (
        input  stall, req_valid,
        input  req_addr0, req_addr1, req_addr2,
        input  req_data0, req_data1, req_data2,
        output req_ready,
        output write_address, write_data, write_enable,
        output write_address2, write_data2, write_enable2,
        output pc_update, pc_write, conflict
    );
endinterface
`default_nettype wire

// File: rtl/regwrite_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : regwrite_scheduler
//  Brief    : Round-robin scheduler of three writeback sources onto two
//             general bank write ports and the PC update port.
//  Revision : 1.0  initial release
// ============================================================================
module regwrite_scheduler #(
    parameter int N = 32
) (
    input  wire logic               clk,
    input  wire logic               rst,
    regwrite_scheduler_if.slave     bus
);

    localparam logic [3:0] C_PC_ADDR = 4'd15;

    function automatic logic [1:0] f_wrap(input logic [2:0] v);
        return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
    endfunction

    logic [3:0]     w_addr [3];
    logic [N-1:0]   w_data [3];

    assign w_addr[0] = bus.req_addr0;
    assign w_addr[1] = bus.req_addr1;
    assign w_addr[2] = bus.req_addr2;
    assign w_data[0] = bus.req_data0;
    assign w_data[1] = bus.req_data1;
    assign w_data[2] = bus.req_data2;

    logic [1:0]     r_rr_ptr;
    logic [3:0]     r_wa1;
    logic [N-1:0]   r_wd1;
    logic           r_we1;
    logic [3:0]     r_wa2;
    logic [N-1:0]   r_wd2;
    logic           r_we2;
    logic [N-1:0]   r_pc;
    logic           r_pcw;
    logic           r_conflict;

    logic [2:0]     w_grant;
    logic           w_p1_use;
    logic           w_p2_use;
    logic           w_pc_use;
    logic [1:0]     w_p1_idx;
    logic [1:0]     w_p2_idx;
    logic [1:0]     w_pc_idx;
    logic [1:0]     w_first_idx;
    logic           w_any;
    logic [1:0]     w_idx;
    logic           w_clash;
    logic           w_take;
    logic           w_defer;

    // Scan in round-robin order; a request is taken only if its port class is
    // free and no earlier grant this cycle targets the same register.
    always_comb begin
        w_grant     = 3'b000;
        w_p1_use    = 1'b0;
        w_p2_use    = 1'b0;
        w_pc_use    = 1'b0;
        w_p1_idx    = 2'd0;
        w_p2_idx    = 2'd0;
        w_pc_idx    = 2'd0;
        w_first_idx = 2'd0;
        w_any       = 1'b0;
        w_idx       = 2'd0;
        w_clash     = 1'b0;
        w_take      = 1'b0;
        for (int k = 0; k < 3; k++) begin
            w_idx   = f_wrap({1'b0, r_rr_ptr} + 3'(k));
            w_clash = 1'b0;
            w_take  = 1'b0;
            for (int j = 0; j < 3; j++) begin
                if (w_grant[j] && (w_addr[j] == w_addr[w_idx])) begin
                    w_clash = 1'b1;
                end
            end
            if (bus.req_valid[w_idx] && !bus.stall && !rst && !w_clash) begin
                if (w_addr[w_idx] == C_PC_ADDR) begin
                    if (!w_pc_use) begin
                        w_pc_use = 1'b1;
                        w_pc_idx = w_idx;
                        w_take   = 1'b1;
                    end
                end else if (!w_p1_use) begin
                    w_p1_use = 1'b1;
                    w_p1_idx = w_idx;
                    w_take   = 1'b1;
                end else if (!w_p2_use) begin
                    w_p2_use = 1'b1;
                    w_p2_idx = w_idx;
                    w_take   = 1'b1;
                end
            end
            if (w_take) begin
                w_grant[w_idx] = 1'b1;
                if (!w_any) begin
                    w_first_idx = w_idx;
                    w_any       = 1'b1;
                end
            end
        end
    end

    assign w_defer = (|(bus.req_valid & ~w_grant)) && !bus.stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr   <= 2'd0;
            r_wa1      <= 4'd0;
            r_wd1      <= '0;
            r_we1      <= 1'b0;
            r_wa2      <= 4'd0;
            r_wd2      <= '0;
            r_we2      <= 1'b0;
            r_pc       <= '0;
            r_pcw      <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            r_we1      <= w_p1_use;
            r_we2      <= w_p2_use;
            r_pcw      <= w_pc_use;
            r_conflict <= w_defer;
            if (w_p1_use) begin
                r_wa1 <= w_addr[w_p1_idx];
                r_wd1 <= w_data[w_p1_idx];
            end
            if (w_p2_use) begin
                r_wa2 <= w_addr[w_p2_idx];
                r_wd2 <= w_data[w_p2_idx];
            end
            if (w_pc_use) begin
                r_pc <= w_data[w_pc_idx];
            end
            if (w_any) begin
                r_rr_ptr <= f_wrap({1'b0, w_first_idx} + 3'd1);
            end
        end
    end

    assign bus.req_ready      = w_grant;
    assign bus.write_address  = r_wa1;
    assign bus.write_data     = r_wd1;
    assign bus.write_enable   = r_we1;
    assign bus.write_address2 = r_wa2;
    assign bus.write_data2    = r_wd2;
    assign bus.write_enable2  = r_we2;
    assign bus.pc_update      = r_pc;
    assign bus.pc_write       = r_pcw;
    assign bus.conflict       = r_conflict;

endmodule
`default_nettype wire

// File: tb/tb_regwrite_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regwrite_scheduler
//  Brief    : Directed vector bench for regwrite_scheduler.
//  Revision : 1.0  initial release
// ============================================================================
module tb_regwrite_scheduler;

    localparam int N = 32;

    logic clk;
    logic rst;

    regwrite_scheduler_if #(.N(N)) bus ();

    regwrite_scheduler #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic           rst;
        logic           stall;
        logic [2:0]     valid;
        logic [3:0]     a0, a1, a2;
        logic [31:0]    d0, d1, d2;
        logic [2:0]     ready;
        logic           we;
        logic [3:0]     wa;
        logic [31:0]    wd;
        logic           we2;
        logic [3:0]     wa2;
        logic [31:0]    wd2;
        logic           pcw;
        logic [31:0]    pc;
        logic           conf;
    } vec_t;

    vec_t vecs [15];
    int   n_vec;
    int   n_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input vec_t v);
        chk("write_enable",   32'(bus.write_enable),   32'(v.we));
        chk("write_address",  32'(bus.write_address),  32'(v.wa));
        chk("write_data",     bus.write_data,          v.wd);
        chk("write_enable2",  32'(bus.write_enable2),  32'(v.we2));
        chk("write_address2", 32'(bus.write_address2), 32'(v.wa2));
        chk("write_data2",    bus.write_data2,         v.wd2);
        chk("pc_write",       32'(bus.pc_write),       32'(v.pcw));
        chk("pc_update",      bus.pc_update,           v.pc);
        chk("conflict",       32'(bus.conflict),       32'(v.conf));
    endtask

    function automatic vec_t mk(
        input logic rst_i, input logic stall_i, input logic [2:0] valid_i,
        input logic [3:0] a0, input logic [31:0] d0,
        input logic [3:0] a1, input logic [31:0] d1,
        input logic [3:0] a2, input logic [31:0] d2,
        input logic [2:0] ready_i,
        input logic we, input logic [3:0] wa, input logic [31:0] wd,
        input logic we2, input logic [3:0] wa2, input logic [31:0] wd2,
        input logic pcw, input logic [31:0] pc, input logic conf);
        vec_t v;
        v.rst = rst_i; v.stall = stall_i; v.valid = valid_i;
        v.a0 = a0; v.a1 = a1; v.a2 = a2;
        v.d0 = d0; v.d1 = d1; v.d2 = d2;
        v.ready = ready_i;
        v.we = we; v.wa = wa; v.wd = wd;
        v.we2 = we2; v.wa2 = wa2; v.wd2 = wd2;
        v.pcw = pcw; v.pc = pc; v.conf = conf;
        return v;
    endfunction

    initial begin
        vec_t zero_v;
        n_vec = 0;
        n_err = 0;

        //            rst st valid a0  d0      a1  d1      a2  d2      rdy  we wa wd      we2 wa2 wd2   pcw pc     conf
        vecs[0]  = mk(0, 0, 3'b001, 3, 32'h0A, 0, 0,      0, 0,      3'b001, 1, 3, 32'h0A, 0, 0, 0,     0, 0,      0);
        // reset wins over a same-cycle handshake
        vecs[1]  = mk(1, 0, 3'b001, 6, 32'h66, 0, 0,      0, 0,      3'b000, 0, 0, 0,      0, 0, 0,     0, 0,      0);
        // oversubscription from rr_ptr=0
        vecs[2]  = mk(0, 0, 3'b111, 1, 32'h101, 2, 32'h202, 3, 32'h303, 3'b011, 1, 1, 32'h101, 1, 2, 32'h202, 0, 0, 1);
        vecs[3]  = mk(0, 0, 3'b100, 1, 32'h101, 2, 32'h202, 3, 32'h303, 3'b100, 1, 3, 32'h303, 0, 2, 32'h202, 0, 0, 0);
        // address clash on r5, rr_ptr back at 0
        vecs[4]  = mk(0, 0, 3'b011, 5, 32'h11, 5, 32'h22, 0, 0,      3'b001, 1, 5, 32'h11, 0, 2, 32'h202, 0, 0,  1);
        vecs[5]  = mk(0, 0, 3'b010, 5, 32'h11, 5, 32'h22, 0, 0,      3'b010, 1, 5, 32'h22, 0, 2, 32'h202, 0, 0,  0);
        vecs[6]  = mk(1, 0, 3'b000, 0, 0,      0, 0,      0, 0,      3'b000, 0, 0, 0,      0, 0, 0,     0, 0,      0);
        // PC routing
        vecs[7]  = mk(0, 0, 3'b111, 15, 32'h100, 4, 32'h7, 15, 32'h200, 3'b011, 1, 4, 32'h7, 0, 0, 0, 1, 32'h100, 1);
        vecs[8]  = mk(0, 0, 3'b100, 15, 32'h100, 4, 32'h7, 15, 32'h200, 3'b100, 0, 4, 32'h7, 0, 0, 0, 1, 32'h200, 0);
        // stall for three cycles, rr_ptr stays 0
        vecs[9]  = mk(0, 1, 3'b111, 7, 32'h77, 8, 32'h88, 9, 32'h99, 3'b000, 0, 4, 32'h7, 0, 0, 0, 0, 32'h200, 0);
        vecs[10] = mk(0, 1, 3'b111, 7, 32'h77, 8, 32'h88, 9, 32'h99, 3'b000, 0, 4, 32'h7, 0, 0, 0, 0, 32'h200, 0);
        vecs[11] = mk(0, 1, 3'b111, 7, 32'h77, 8, 32'h88, 9, 32'h99, 3'b000, 0, 4, 32'h7, 0, 0, 0, 0, 32'h200, 0);
        vecs[12] = mk(0, 0, 3'b111, 7, 32'h77, 8, 32'h88, 9, 32'h99, 3'b011, 1, 7, 32'h77, 1, 8, 32'h88, 0, 32'h200, 1);
        // rr_ptr=1: scan 1,2,0
        vecs[13] = mk(0, 0, 3'b111, 7, 32'h77, 8, 32'h88, 9, 32'h99, 3'b110, 1, 8, 32'h88, 1, 9, 32'h99, 0, 32'h200, 1);
        // rr_ptr=2: all to PC, only requester 2 wins
        vecs[14] = mk(0, 0, 3'b111, 15, 32'hA0, 15, 32'hA1, 15, 32'hA2, 3'b100, 0, 8, 32'h88, 0, 9, 32'h99, 1, 32'hA2, 1);

        zero_v = mk(0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        rst = 1'b1;
        bus.stall = 1'b0;
        bus.req_valid = 3'b000;
        bus.req_addr0 = 4'd0; bus.req_addr1 = 4'd0; bus.req_addr2 = 4'd0;
        bus.req_data0 = '0;   bus.req_data1 = '0;   bus.req_data2 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_outs(zero_v);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            rst           = vecs[i].rst;
            bus.stall     = vecs[i].stall;
            bus.req_valid = vecs[i].valid;
            bus.req_addr0 = vecs[i].a0;
            bus.req_addr1 = vecs[i].a1;
            bus.req_addr2 = vecs[i].a2;
            bus.req_data0 = vecs[i].d0;
            bus.req_data1 = vecs[i].d1;
            bus.req_data2 = vecs[i].d2;
            #1;
            chk("req_ready", 32'(bus.req_ready), 32'(vecs[i].ready));
            @(posedge clk);
            #1;
            chk_outs(vecs[i]);
        end
        rst = 1'b0;

        // A stall raised right after a grant does not cancel the registered write.
        bus.stall     = 1'b0;
        bus.req_valid = 3'b001;
        bus.req_addr0 = 4'd10;
        bus.req_data0 = 32'hAB;
        #1;
        chk("seq_ready_grant", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.stall     = 1'b1;
        bus.req_valid = 3'b010;
        bus.req_addr1 = 4'd11;
        #1;
        chk("seq_ready_stalled", 32'(bus.req_ready), 32'd0);
        chk("seq_we_in_stall", 32'(bus.write_enable), 32'd1);
        chk("seq_wa_in_stall", 32'(bus.write_address), 32'd10);
        chk("seq_wd_in_stall", bus.write_data, 32'hAB);
        @(posedge clk);
        #1;
        chk("seq_we_after_stall", 32'(bus.write_enable), 32'd0);
        chk("seq_conf_after_stall", 32'(bus.conflict), 32'd0);
        // rr_ptr is 1 after the r10 grant: released stall grants requester 1 on port 1
        bus.stall = 1'b0;
        #1;
        chk("seq_ready_release", 32'(bus.req_ready), 32'd2);
        @(posedge clk);
        #1;
        chk("seq_wa_release", 32'(bus.write_address), 32'd11);
        chk("seq_we_release", 32'(bus.write_enable), 32'd1);
        bus.req_valid = 3'b000;
        @(posedge clk);
        #1;
        chk("seq_we_idle", 32'(bus.write_enable), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
